// File: rtl/decoder_width_pkg.sv
// Shared types and constants for the width-selectable one-hot decoder.
package decoder_width_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   localparam int SUPPORTED_WIDTH_2 = 2;
   localparam int SUPPORTED_WIDTH_4 = 4;
   localparam int SUPPORTED_WIDTH_8 = 8;

   localparam int unsigned CNT_W = 16;

   function automatic bit is_supported(int w);
      return (w == SUPPORTED_WIDTH_2) || (w == SUPPORTED_WIDTH_4) || (w == SUPPORTED_WIDTH_8);
   endfunction

endpackage

// File: rtl/decoder_skid_stage.sv
// Generic 2-entry valid/ready buffer: registered output word plus one skid word.
// No combinational path from in_valid/in_data to the output side.
module decoder_skid_stage
   import decoder_width_pkg::*;
#(
   parameter int unsigned DATA_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              accept;
   logic              fire;

   assign in_ready  = !rst && (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = out_q;
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;

   // Next state: the skid word is only ever filled from ONE when the output stalls.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               out_d   = in_data;
               state_d = ONE;
            end
         end
         ONE: begin
            if (accept && !fire) begin
               skid_d  = in_data;
               state_d = TWO;
            end else if (accept && fire) begin
               out_d   = in_data;
            end else if (fire) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (fire) begin
               out_d   = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         out_q   <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/decoder_width_selector.sv
// Width-selectable binary-to-one-hot decoder behind a 2-entry output buffer.
// Define DECODER_WIDTH_STATS_EN to enable the decode_count / zero_count statistics.
module decoder_width_selector
   import decoder_width_pkg::*;
#(
   parameter int unsigned WIDTH  = 4,
   parameter int unsigned CODE_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] in_code,
   input  logic              in_code_vld,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_onehot,
   output logic [CNT_W-1:0]  decode_count,
   output logic [CNT_W-1:0]  zero_count
);

   generate
      case (WIDTH)
         SUPPORTED_WIDTH_2, SUPPORTED_WIDTH_4, SUPPORTED_WIDTH_8: begin : g_dec
            logic [WIDTH-1:0] onehot_c;
            logic [WIDTH:0]   buf_data;
            logic             buf_valid;
            logic             fire;

            // Top bit travels with the word so stats see the code_vld of the fired word.
            assign onehot_c = in_code_vld ? (WIDTH'(1) << in_code) : '0;

            decoder_skid_stage #(
               .DATA_W (WIDTH + 1)
            ) u_skid (
               .clk       (clk),
               .rst       (rst),
               .in_valid  (in_valid),
               .in_ready  (in_ready),
               .in_data   ({in_code_vld, onehot_c}),
               .out_valid (buf_valid),
               .out_ready (out_ready),
               .out_data  (buf_data)
            );

            assign out_valid  = buf_valid;
            assign out_onehot = buf_data[WIDTH-1:0];
            assign fire       = buf_valid && out_ready;

`ifdef DECODER_WIDTH_STATS_EN
            logic [CNT_W-1:0] decode_count_q, decode_count_d;
            logic [CNT_W-1:0] zero_count_q, zero_count_d;

            // Saturating transfer statistics.
            always_comb begin
               decode_count_d = decode_count_q;
               zero_count_d   = zero_count_q;
               if (fire && (decode_count_q != {CNT_W{1'b1}})) begin
                  decode_count_d = decode_count_q + CNT_W'(1);
               end
               if (fire && !buf_data[WIDTH] && (zero_count_q != {CNT_W{1'b1}})) begin
                  zero_count_d = zero_count_q + CNT_W'(1);
               end
            end

            always_ff @(posedge clk) begin
               if (rst) begin
                  decode_count_q <= '0;
                  zero_count_q   <= '0;
               end else begin
                  decode_count_q <= decode_count_d;
                  zero_count_q   <= zero_count_d;
               end
            end

            assign decode_count = decode_count_q;
            assign zero_count   = zero_count_q;
`else
            logic unused_stats;
            assign unused_stats = ^{fire, buf_data[WIDTH]};
            assign decode_count = '0;
            assign zero_count   = '0;
`endif
         end
         default: begin : g_unsupported
            initial $display("ERROR: decoder_width_selector WIDTH=%0d unsupported", WIDTH);
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, in_valid, in_code, in_code_vld, out_ready};
            assign in_ready      = 1'b0;
            assign out_valid     = 1'b0;
            assign out_onehot    = '0;
            assign decode_count  = '0;
            assign zero_count    = '0;
         end
      endcase
   endgenerate

endmodule

// File: tb/tb_decoder_width_selector.sv
// Directed bench for decoder_width_selector at WIDTH 2, 4, 8 and the unsupported WIDTH 6.
module tb_decoder_width_selector;

`ifdef DECODER_WIDTH_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // WIDTH=4
   logic        iv4 = 0, ir4, cv4 = 0, ov4, or4 = 0;
   logic [1:0]  ic4 = '0;
   logic [3:0]  oh4;
   logic [15:0] dc4, zc4;
   // WIDTH=8
   logic        iv8 = 0, ir8, cv8 = 0, ov8, or8 = 0;
   logic [2:0]  ic8 = '0;
   logic [7:0]  oh8;
   logic [15:0] dc8, zc8;
   // WIDTH=2
   logic        iv2 = 0, ir2, cv2 = 0, ov2, or2 = 0;
   logic [0:0]  ic2 = '0;
   logic [1:0]  oh2;
   logic [15:0] dc2, zc2;
   // WIDTH=6 (unsupported)
   logic        iv6 = 0, ir6, cv6 = 0, ov6, or6 = 0;
   logic [2:0]  ic6 = '0;
   logic [5:0]  oh6;
   logic [15:0] dc6, zc6;

   decoder_width_selector #(.WIDTH(4)) u4 (
      .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in_code(ic4), .in_code_vld(cv4),
      .out_valid(ov4), .out_ready(or4), .out_onehot(oh4), .decode_count(dc4), .zero_count(zc4));
   decoder_width_selector #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_code(ic8), .in_code_vld(cv8),
      .out_valid(ov8), .out_ready(or8), .out_onehot(oh8), .decode_count(dc8), .zero_count(zc8));
   decoder_width_selector #(.WIDTH(2)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_code(ic2), .in_code_vld(cv2),
      .out_valid(ov2), .out_ready(or2), .out_onehot(oh2), .decode_count(dc2), .zero_count(zc2));
   decoder_width_selector #(.WIDTH(6)) u6 (
      .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .in_code(ic6), .in_code_vld(cv6),
      .out_valid(ov6), .out_ready(or6), .out_onehot(oh6), .decode_count(dc6), .zero_count(zc6));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (ir4 !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b exp 0", ir4); end
         n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b exp 0", ov4); end
         n_cmp++; if (oh4 !== 4'b0000) begin n_bad++; $display("FAIL rst_onehot: got %b exp 0000", oh4); end
      end
      rst = 1'b0;
      step();
      n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL post_rst_in_ready: got %b exp 1", ir4); end
      n_cmp++; if (dc4 !== 16'd0) begin n_bad++; $display("FAIL post_rst_decode_count: got %0d exp 0", dc4); end
      n_cmp++; if (zc4 !== 16'd0) begin n_bad++; $display("FAIL post_rst_zero_count: got %0d exp 0", zc4); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_oh [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      or4 = 1'b1;
      cv4 = 1'b1;
      iv4 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ic4 = 2'(i);
         step();
         n_cmp++; if (ov4 !== 1'b1) begin n_bad++; $display("FAIL b2b_out_valid[%0d]: got %b exp 1", i, ov4); end
         n_cmp++; if (oh4 !== exp_oh[i]) begin n_bad++; $display("FAIL b2b_onehot[%0d]: got %b exp %b", i, oh4, exp_oh[i]); end
         n_cmp++; if (ir4 !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready[%0d]: got %b exp 1", i, ir4); end
      end
      iv4 = 1'b0;
      step();
      n_cmp++; if (ov4 !== 1'b0) begin n_bad++; $display("FAIL b2b_drain_valid: got %b exp 0", ov4); end
      n_cmp++; if (dc4 !== (STATS_ON ? 16'd4 : 16'd0)) begin n_bad++; $display("FAIL b2b_decode_count: got %0d exp %0d", dc4, STATS_ON ? 4 : 0); end
      n_cmp++; if (zc4 !== 16'd0) begin n_bad++; $display("FAIL b2b_zero_count: got %0d exp 0", zc4); end
      or4 = 1'b0;
   endtask

   task automatic test_backpressure();
      or8 = 1'b0;
      cv8 = 1'b1;
      iv8 = 1'b1;
      ic8 = 3'd5;
      step();
      n_cmp++; if (oh8 !== 8'h20) begin n_bad++; $display("FAIL bp_first_onehot: got %h exp 20", oh8); end
      n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL bp_first_in_ready: got %b exp 1", ir8); end
      ic8 = 3'd2;
      step();
      iv8 = 1'b0;
      n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL bp_full_in_ready: got %b exp 0", ir8); end
      n_cmp++; if (oh8 !== 8'h20) begin n_bad++; $display("FAIL bp_full_onehot: got %h exp 20", oh8); end
      step();
      n_cmp++; if (oh8 !== 8'h20 || ov8 !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %h/%b exp 20/1", oh8, ov8); end
      or8 = 1'b1;
      step();
      n_cmp++; if (oh8 !== 8'h04) begin n_bad++; $display("FAIL bp_second_onehot: got %h exp 04", oh8); end
      n_cmp++; if (ir8 !== 1'b1) begin n_bad++; $display("FAIL bp_ready_back: got %b exp 1", ir8); end
      step();
      n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b exp 0", ov8); end
      n_cmp++; if (dc8 !== (STATS_ON ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL bp_decode_count: got %0d exp %0d", dc8, STATS_ON ? 2 : 0); end
      or8 = 1'b0;
   endtask

   task automatic test_zero_code();
      or2 = 1'b1;
      iv2 = 1'b1;
      ic2 = 1'b1;
      cv2 = 1'b1;
      step();
      n_cmp++; if (oh2 !== 2'b10) begin n_bad++; $display("FAIL w2_code1: got %b exp 10", oh2); end
      cv2 = 1'b0;
      step();
      iv2 = 1'b0;
      n_cmp++; if (oh2 !== 2'b00 || ov2 !== 1'b1) begin n_bad++; $display("FAIL w2_zero_word: got %b/%b exp 00/1", oh2, ov2); end
      step();
      n_cmp++; if (zc2 !== (STATS_ON ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL w2_zero_count: got %0d exp %0d", zc2, STATS_ON ? 1 : 0); end
      n_cmp++; if (dc2 !== (STATS_ON ? 16'd2 : 16'd0)) begin n_bad++; $display("FAIL w2_decode_count: got %0d exp %0d", dc2, STATS_ON ? 2 : 0); end
      or2 = 1'b0;
   endtask

   task automatic test_reset_mid_transfer();
      or8 = 1'b0;
      cv8 = 1'b1;
      iv8 = 1'b1;
      ic8 = 3'd3;
      step();
      ic8 = 3'd6;
      step();
      iv8 = 1'b0;
      n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL mid_two_in_ready: got %b exp 0", ir8); end
      rst = 1'b1;
      step();
      n_cmp++; if (ov8 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b exp 0", ov8); end
      n_cmp++; if (oh8 !== 8'h00) begin n_bad++; $display("FAIL mid_rst_onehot: got %h exp 00", oh8); end
      n_cmp++; if (ir8 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_in_ready: got %b exp 0", ir8); end
      rst = 1'b0;
      or8 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (ov8 !== 1'b0 || oh8 !== 8'h00) begin n_bad++; $display("FAIL mid_post_word[%0d]: got %b/%h exp 0/00", i, ov8, oh8); end
      end
      n_cmp++; if (dc8 !== 16'd0) begin n_bad++; $display("FAIL mid_decode_count: got %0d exp 0", dc8); end
      or8 = 1'b0;
   endtask

   task automatic test_unsupported();
      iv6 = 1'b1;
      cv6 = 1'b1;
      ic6 = 3'd2;
      or6 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (ir6 !== 1'b0 || ov6 !== 1'b0) begin n_bad++; $display("FAIL w6_handshake[%0d]: got %b/%b exp 0/0", i, ir6, ov6); end
         n_cmp++; if (oh6 !== 6'd0 || dc6 !== 16'd0 || zc6 !== 16'd0) begin n_bad++; $display("FAIL w6_outputs[%0d]: got %h/%0d/%0d exp 0", i, oh6, dc6, zc6); end
      end
      iv6 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_backpressure();
      test_zero_code();
      test_reset_mid_transfer();
      test_unsupported();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
